// File: rtl/lim_counter_chain.sv
// Multi-digit modulo-L counter: D cascaded digits, each 0..L-1, with up/down, clear, range-checked load.
// Optional macro LIM_COUNTER_SATURATE_EN: saturate at the extremes instead of wrapping (co still flags it).
module lim_counter_chain #(
    parameter int L = 9,
    parameter int D = 2,
    parameter int N = $clog2(L)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           up_dn,
    input  logic           clr,
    input  logic           load,
    input  logic [D*N-1:0] load_val,
    output logic [D*N-1:0] count,
    output logic           co,
    output logic           load_err
);

    localparam logic [N-1:0] DMAX = N'(L - 1);
    localparam logic [N:0]   LIM  = (N + 1)'(L);

    logic [D*N-1:0] count_q, count_d;
    logic           co_q, co_d;
    logic           err_q, err_d;

    logic [D*N-1:0] stepped;
    logic           wrap;
    logic [D*N-1:0] loaded;
    logic           bad_digit;

    // One ripple step across all digits; MSB of the result is set when every digit wrapped.
    function automatic logic [D*N:0] step_all(input logic [D*N-1:0] c, input logic up);
        logic [D*N-1:0] nxt;
        logic           ripple;
        logic [N-1:0]   dig;
        nxt    = c;
        ripple = 1'b1;
        for (int i = 0; i < D; i++) begin
            dig = c[i*N +: N];
            if (ripple) begin
                if (up) begin
                    if (dig == DMAX) begin
                        nxt[i*N +: N] = '0;
                    end else begin
                        nxt[i*N +: N] = dig + N'(1);
                        ripple        = 1'b0;
                    end
                end else begin
                    if (dig == '0) begin
                        nxt[i*N +: N] = DMAX;
                    end else begin
                        nxt[i*N +: N] = dig - N'(1);
                        ripple        = 1'b0;
                    end
                end
            end
        end
        return {ripple, nxt};
    endfunction

    // Out-of-range digits load as 0; MSB of the result reports whether any were seen.
    function automatic logic [D*N:0] load_fix(input logic [D*N-1:0] v);
        logic [D*N-1:0] fixed;
        logic           err;
        logic [N-1:0]   dig;
        fixed = '0;
        err   = 1'b0;
        for (int i = 0; i < D; i++) begin
            dig = v[i*N +: N];
            if ({1'b0, dig} < LIM) begin
                fixed[i*N +: N] = dig;
            end else begin
                err = 1'b1;
            end
        end
        return {err, fixed};
    endfunction

    assign {wrap, stepped}     = step_all(count_q, up_dn);
    assign {bad_digit, loaded} = load_fix(load_val);

    always_comb begin
        count_d = count_q;
        co_d    = 1'b0;
        err_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = loaded;
            err_d   = bad_digit;
        end else if (en) begin
            co_d = wrap;
`ifdef LIM_COUNTER_SATURATE_EN
            count_d = wrap ? count_q : stepped;
`else
            count_d = stepped;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            co_q    <= co_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign co       = co_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_lim_counter_chain.sv
// Self-checking bench for lim_counter_chain (L=9, D=2): vector table, reset corner cases, random vs value model.
module tb_lim_counter_chain;

    localparam int L    = 9;
    localparam int D    = 2;
    localparam int N    = $clog2(L);
    localparam int W    = D * N;
    localparam int MODV = L ** D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, up_dn, clr, load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         co, load_err;

    int pass_cnt = 0;
    int total    = 0;

    // Reference state: the counter as a single integer in 0..L^D-1.
    int mv;
    bit mco, merr;

    typedef struct {
        string        nm;
        bit           c, l, e, u;
        logic [W-1:0] lv;
        logic [W-1:0] ec;
        bit           eco, eerr;
    } vec_t;

    vec_t tbl[$];

    lim_counter_chain #(.L(L), .D(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .co       (co),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_packed(input int v);
        logic [W-1:0] p;
        int           x;
        p = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            p[i*N +: N] = N'(x % L);
            x = x / L;
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Drive one request, advance the model, and let the edge happen; returns sampled #1 after the edge.
    task automatic drive(input bit c, input bit l, input logic [W-1:0] lv, input bit e, input bit u);
        int acc, pw, d;
        clr = c; load = l; load_val = lv; en = e; up_dn = u;
        if (c) begin
            mv = 0; mco = 0; merr = 0;
        end else if (l) begin
            acc = 0; pw = 1; merr = 0;
            for (int i = 0; i < D; i++) begin
                d = int'(lv[i*N +: N]);
                if (d >= L) begin
                    merr = 1;
                    d = 0;
                end
                acc += d * pw;
                pw  *= L;
            end
            mv = acc; mco = 0;
        end else if (e) begin
            merr = 0;
            if (u) begin
                mco = (mv == MODV - 1);
`ifdef LIM_COUNTER_SATURATE_EN
                if (!mco) mv = mv + 1;
`else
                mv = (mv + 1) % MODV;
`endif
            end else begin
                mco = (mv == 0);
`ifdef LIM_COUNTER_SATURATE_EN
                if (!mco) mv = mv - 1;
`else
                mv = (mv + MODV - 1) % MODV;
`endif
            end
        end else begin
            mco = 0; merr = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".count"}, 32'(count), 32'(to_packed(mv)));
        chk({nm, ".co"}, 32'(co), 32'(mco));
        chk({nm, ".load_err"}, 32'(load_err), 32'(merr));
    endtask

    function automatic void add(input string nm, input bit c, input bit l, input logic [W-1:0] lv,
                                input bit e, input bit u, input logic [W-1:0] ec, input bit eco,
                                input bit eerr);
        vec_t v;
        v.nm = nm; v.c = c; v.l = l; v.lv = lv; v.e = e; v.u = u;
        v.ec = ec; v.eco = eco; v.eerr = eerr;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [W-1:0] rv;
        int           r;

        rst_n = 1'b0; en = 0; up_dn = 0; clr = 0; load = 0; load_val = '0;
        mv = 0; mco = 0; merr = 0;
        #1;
        chk("reset.count", 32'(count), 32'h00);
        chk("reset.co", 32'(co), 32'h0);
        chk("reset.load_err", 32'(load_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Expected values written out by hand in base-9 nibble notation.
        for (int i = 1; i <= 8; i++) add("ripple", 0, 0, 8'h00, 1, 1, 8'(i), 0, 0);
        add("ripple.carry", 0, 0, 8'h00, 1, 1, 8'h10, 0, 0);
        add("load88", 0, 1, 8'h88, 0, 0, 8'h88, 0, 0);
`ifdef LIM_COUNTER_SATURATE_EN
        add("wrap_up", 0, 0, 8'h00, 1, 1, 8'h88, 1, 0);
        add("wrap_up.after", 0, 0, 8'h00, 0, 1, 8'h88, 0, 0);
        add("clr", 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        add("wrap_dn", 0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
        add("wrap_dn.next", 0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
`else
        add("wrap_up", 0, 0, 8'h00, 1, 1, 8'h00, 1, 0);
        add("wrap_up.after", 0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
        add("clr", 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        add("wrap_dn", 0, 0, 8'h00, 1, 0, 8'h88, 1, 0);
        add("wrap_dn.next", 0, 0, 8'h00, 1, 0, 8'h87, 0, 0);
`endif
        add("load3C", 0, 1, 8'h3C, 0, 0, 8'h30, 0, 1);
        add("load3C.after", 0, 0, 8'h00, 0, 0, 8'h30, 0, 0);
        add("load47", 0, 1, 8'h47, 0, 0, 8'h47, 0, 0);
        add("loadF9", 0, 1, 8'hF9, 0, 0, 8'h00, 0, 1);
        add("prio.clr", 1, 1, 8'h25, 1, 1, 8'h00, 0, 0);
        add("prio.load", 0, 1, 8'h25, 1, 1, 8'h25, 0, 0);
        add("dn", 0, 0, 8'h00, 1, 0, 8'h24, 0, 0);
        add("dir_flip", 0, 0, 8'h00, 1, 1, 8'h25, 0, 0);
        add("borrow", 0, 1, 8'h30, 0, 0, 8'h30, 0, 0);
        add("borrow.step", 0, 0, 8'h00, 1, 0, 8'h28, 0, 0);

        foreach (tbl[k]) begin
            drive(tbl[k].c, tbl[k].l, tbl[k].lv, tbl[k].e, tbl[k].u);
            chk({tbl[k].nm, ".count"}, 32'(count), 32'(tbl[k].ec));
            chk({tbl[k].nm, ".co"}, 32'(co), 32'(tbl[k].eco));
            chk({tbl[k].nm, ".load_err"}, 32'(load_err), 32'(tbl[k].eerr));
        end

        // Asynchronous reset while co and load_err are both clear-able: catch co high first.
        drive(0, 1, 8'h88, 0, 0);
        drive(0, 0, 8'h00, 1, 1);
        chk("pre_rst.co", 32'(co), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.count", 32'(count), 32'h00);
        chk("async_rst.co", 32'(co), 32'h0);
        mv = 0; mco = 0; merr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Async reset mid-count at 0x35, then resume counting from zero.
        drive(0, 1, 8'h34, 0, 0);
        drive(0, 0, 8'h00, 1, 1);
        chk("to35.count", 32'(count), 32'h35);
        #3 rst_n = 1'b0;
        #1;
        chk("rst35.count", 32'(count), 32'h00);
        chk("rst35.co", 32'(co), 32'h0);
        mv = 0; mco = 0; merr = 0;
        #2 rst_n = 1'b1;
        drive(0, 0, 8'h00, 1, 1);
        chk("post_rst.count", 32'(count), 32'h01);

        // Bad-load error pulse lasts exactly one cycle even while further loads are good.
        drive(0, 1, 8'h9A, 0, 0);
        chk("err.pulse", 32'(load_err), 32'h1);
        drive(0, 1, 8'h11, 0, 0);
        chk("err.cleared", 32'(load_err), 32'h0);

        // Random traffic against the value model; loads are biased toward the extremes.
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = $urandom_range(0, 99);
            rv = 8'($urandom);
            if (r < 4) drive(1, $urandom_range(0, 1) != 0, rv, $urandom_range(0, 1) != 0, 1);
            else if (r < 12) drive(0, 1, rv, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
            else if (r < 16) drive(0, 1, ($urandom_range(0, 1) != 0) ? 8'h88 : 8'h00, 0, 0);
            else drive(0, 0, rv, r < 85, $urandom_range(0, 2) != 0);
            chk_model($sformatf("rand%0d", cyc));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/lim_counter_chain.md
Name: lim_counter_chain

Overview:
Parametrised multi-digit modulo-L counter built as a registered cascade of limited incrementors/decrementors. Each digit counts 0..L-1; a digit passes its carry or borrow to the next digit up. Adds up/down mode, synchronous clear, parallel load with range checking, and a terminal-carry pulse. Used for lab timers, stopwatches and display counters that feed the 7-segment path.

Parameters:
L, 9, digit modulus; each digit holds 0..L-1; legal range 2..16
D, 2, number of cascaded digits; legal range 1..8
N, $clog2(L), derived digit width in bits; not overridden by users

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  count-step qualifier; one step per clk cycle while high
up_dn  in  1  1 = count up, 0 = count down; sampled only when en=1
clr  in  1  synchronous clear to all-zero
load  in  1  synchronous parallel load
load_val  in  D*N  load value; digit i at bits [i*N+N-1 : i*N]
count  out  D*N  registered counter value, same digit packing as load_val
co  out  1  registered terminal carry/borrow pulse
load_err  out  1  registered pulse: the load value contained an out-of-range digit

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, co=0, load_err=0 immediately, independent of clk.
  - Reset may be asserted mid-count; counting resumes from 0 on the first clk edge after rst_n=1.
- Priority per clk edge: clr > load > en. Only the highest active request takes effect.
- clr=1:
  - count<=0, co<=0, load_err<=0.
- load=1 (clr=0):
  - Each digit d of load_val is loaded as d if d<L, otherwise as 0.
  - load_err<=1 if any digit is >=L, else 0.
  - co<=0.
- Count up (en=1, up_dn=1, clr=0, load=0):
  - Digit 0 increments.
  - Digit i (i>0) increments only if every digit below it equals L-1.
  - A digit at L-1 that increments goes to 0 and carries.
  - If all digits equal L-1, count<=0 and co<=1.
- Count down (en=1, up_dn=0, clr=0, load=0):
  - Digit 0 decrements.
  - Digit i (i>0) decrements only if every digit below it equals 0.
  - A digit at 0 that decrements goes to L-1 and borrows.
  - If all digits equal 0, every digit<=L-1 and co<=1.
- Idle (en=0, clr=0, load=0): count holds; co<=0; load_err<=0.
- Pulse widths:
  - co is high for exactly one cycle, the cycle in which count shows the post-wrap value.
  - load_err is high for exactly one cycle after the offending load.
- up_dn may change on any cycle; the counter has no direction state.
- Latency: count, co and load_err update on the clk edge that samples the request (1-cycle registered).
- Arithmetic:
  - Per-digit values are never >=L after reset, clr or load.
  - Digits with N bits that can encode values >=L (e.g. 9..15 when L=9) are unreachable.

Optional Feature:
Macro LIM_COUNTER_SATURATE_EN.
- Defined:
  - Counting up from all-(L-1), or down from all-0, leaves count unchanged (saturates).
  - co<=1 for that cycle, as an overflow/underflow flag.
  - All other behaviour is identical.
- Not defined: wrap-around behaviour as specified above.

Test Plan:
- Reset: L=9, D=2. Count to 0x35, then pulse rst_n=0 between edges -> count=0x00 and co=0 without waiting for a clk edge. Release, 1 up step -> count=0x01.
- Carry ripple: from 0x00, en=1 up for 9 cycles -> count 0x01..0x08, then 0x10. co stays 0 throughout.
- Wrap up: load 0x88, then one up step -> count=0x00, co=1 for one cycle, then co=0. With LIM_COUNTER_SATURATE_EN: count stays 0x88, co=1 for one cycle.
- Wrap down: from 0x00, one down step -> count=0x88, co=1. Next down step -> 0x87, co=0. With the macro: count stays 0x00, co=1.
- Load range check: load_val=0x3C -> count=0x30, load_err=1 for one cycle. load_val=0x47 -> count=0x47, load_err=0.
- Priority: clr=1, load=1 (load_val=0x25) and en=1 in the same cycle -> count=0x00, co=0, load_err=0. Next cycle load=1 and en=1 -> count=0x25 (no step applied).
